// File: rtl/wb_arbiter_pkg.sv
// Shared types for the two-requester Wishbone arbiter.
// Owner state encoding and grant bit patterns.
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    function automatic logic [1:0] gnt_of(arb_state_t s);
        case (s)
            OWN0:    return GNT_M0;
            OWN1:    return GNT_M1;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bus bundle.
// master drives the request side, slave returns ack and read data.
interface wshb_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADR_W      = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [DATA_BYTES-1:0]   sel;
    logic [ADR_W-1:0]        adr;
    logic [8*DATA_BYTES-1:0] dat_w;
    logic [8*DATA_BYTES-1:0] dat_r;
    logic                    ack;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-requester Wishbone arbiter with round-robin ties,
// a bus-release gap cycle and a stalled-slave watchdog.
module wb_arbiter_2m
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    wshb_if.slave      wb_s0,
    wshb_if.slave      wb_s1,
    wshb_if.master     wb_m,
    output logic [1:0] grant,
    output logic       timeout_evt
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t state;
    arb_state_t state_nx;
    logic last_owner;
    logic lock0;
    logic lock1;
    logic [CW-1:0] cnt;

    logic own0;
    logic own1;
    logic own;
    logic req0;
    logic req1;
    logic pick1;
    logic owner_cyc;
    logic owner_stb;
    logic stall;
    logic [8*DATA_BYTES-1:0] rdata;

    assign own0  = (state == OWN0);
    assign own1  = (state == OWN1);
    assign own   = own0 | own1;
    assign req0  = wb_s0.cyc & ~lock0;
    assign req1  = wb_s1.cyc & ~lock1;
    assign pick1 = req1 & (~req0 | ~last_owner);
    assign rdata = wb_m.dat_r;

    assign owner_cyc = own0 ? wb_s0.cyc : wb_s1.cyc;
    assign owner_stb = own0 ? wb_s0.stb : wb_s1.stb;
    assign stall     = own & owner_cyc & owner_stb & ~wb_m.ack;

    // Fires on the TIMEOUT-th consecutive stalled owner cycle.
    assign timeout_evt = ~rst & stall & (cnt == CNT_LAST);

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            own0: if (timeout_evt | ~wb_s0.cyc) state_nx = GAP;
            own1: if (timeout_evt | ~wb_s1.cyc) state_nx = GAP;
            default: begin
                if (req0 | req1) state_nx = pick1 ? OWN1 : OWN0;
                else             state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GNT_NONE;
            last_owner <= 1'b1;
            lock0      <= 1'b0;
            lock1      <= 1'b0;
            cnt        <= '0;
        end else begin
            state <= state_nx;
            grant <= gnt_of(state_nx);
            if (!own && state_nx == OWN0) last_owner <= 1'b0;
            if (!own && state_nx == OWN1) last_owner <= 1'b1;
            cnt   <= (stall && !timeout_evt) ? cnt + CW'(1) : '0;
            // Lockout holds until the requester is seen with cyc low.
            lock0 <= (timeout_evt & own0) | (lock0 & wb_s0.cyc);
            lock1 <= (timeout_evt & own1) | (lock1 & wb_s1.cyc);
        end
    end

    always_comb begin
        wb_m.cyc    = 1'b0;
        wb_m.stb    = 1'b0;
        wb_m.we     = 1'b0;
        wb_m.sel    = '0;
        wb_m.adr    = '0;
        wb_m.dat_w  = '0;
        wb_s0.ack   = 1'b0;
        wb_s0.dat_r = '0;
        wb_s1.ack   = 1'b0;
        wb_s1.dat_r = '0;
        unique case (1'b1)
            own0: begin
                wb_m.cyc    = wb_s0.cyc;
                wb_m.stb    = wb_s0.stb;
                wb_m.we     = wb_s0.we;
                wb_m.sel    = wb_s0.sel;
                wb_m.adr    = wb_s0.adr;
                wb_m.dat_w  = wb_s0.dat_w;
                wb_s0.ack   = wb_m.ack & ~rst;
                wb_s0.dat_r = rdata;
            end
            own1: begin
                wb_m.cyc    = wb_s1.cyc;
                wb_m.stb    = wb_s1.stb;
                wb_m.we     = wb_s1.we;
                wb_m.sel    = wb_s1.sel;
                wb_m.adr    = wb_s1.adr;
                wb_m.dat_w  = wb_s1.dat_w;
                wb_s1.ack   = wb_m.ack & ~rst;
                wb_s1.dat_r = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: vector table for arbitration,
// scripted transfers with a read-data scoreboard.
module tb_wb_arbiter_2m;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] grant;
    logic timeout_evt;

    always #5 clk = ~clk;

    wshb_if s0_if ();
    wshb_if s1_if ();
    wshb_if m_if ();

    wb_arbiter_2m #(.DATA_BYTES(4), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_s0      (s0_if),
        .wb_s1      (s1_if),
        .wb_m       (m_if),
        .grant      (grant),
        .timeout_evt(timeout_evt)
    );

    // memory slave stub: registered ack, optional stall and forced ack
    logic [31:0] smem [16];
    logic [31:0] mmem [16];
    logic ack_q;
    logic force_ack;
    logic no_ack;
    logic mem_init;

    assign m_if.ack = ack_q | force_ack;

    always @(posedge clk) begin
        if (mem_init)
            for (int i = 0; i < 16; i++) smem[i] <= 32'h1111_0000 + 32'(i);
        if (rst) begin
            ack_q <= 1'b0;
        end else if (m_if.cyc && m_if.stb && !ack_q && !no_ack) begin
            ack_q <= 1'b1;
            if (m_if.we) smem[m_if.adr[5:2]] <= m_if.dat_w;
            else         m_if.dat_r <= smem[m_if.adr[5:2]];
        end else begin
            ack_q <= 1'b0;
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int acks0 = 0;
    int acks1 = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd_check(input logic [31:0] dat);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected read ack: got %h expected none", dat);
        end else begin
            chk("read data", dat, exp_q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (s0_if.ack) acks0++;
        if (s1_if.ack) acks1++;
        if (s0_if.ack && !s0_if.we) rd_check(s0_if.dat_r);
        if (s1_if.ack && !s1_if.we) rd_check(s1_if.dat_r);
    end

    task automatic drv(input int idx, input logic cyc, input logic stb,
                       input logic we, input logic [31:0] adr,
                       input logic [31:0] dat);
        if (idx == 0) begin
            s0_if.cyc = cyc; s0_if.stb = stb; s0_if.we = we;
            s0_if.sel = 4'hF; s0_if.adr = adr; s0_if.dat_w = dat;
        end else begin
            s1_if.cyc = cyc; s1_if.stb = stb; s1_if.we = we;
            s1_if.sel = 4'hF; s1_if.adr = adr; s1_if.dat_w = dat;
        end
    endtask

    function automatic logic ack_of(input int idx);
        return (idx == 0) ? s0_if.ack : s1_if.ack;
    endfunction

    // n-beat transfer holding cyc; starts and ends just after a posedge
    task automatic burst(input int idx, input int n, input logic we,
                         input logic [31:0] base, input logic [31:0] dat0,
                         input bit chk_lat);
        logic [31:0] a;
        logic [31:0] d;
        int lat;
        bit got;
        for (int b = 0; b < n; b++) begin
            a = base + 32'(4 * b);
            d = dat0 + 32'(b);
            if (we) mmem[a[5:2]] = d;
            else    exp_q.push_back(mmem[a[5:2]]);
            drv(idx, 1'b1, 1'b1, we, a, d);
            if (b == 0 && chk_lat) begin
                lat = -1;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (grant[idx]) begin lat = k; break; end
                end
                chk("grant latency", 32'(lat), 32'd1);
            end
            got = 1'b0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (ack_of(idx)) begin got = 1'b1; break; end
            end
            chk("ack within budget", {31'd0, got}, 32'd1);
            @(posedge clk);
            #1;
        end
        drv(idx, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic c0, s0, c1, s1, fa;
        logic [1:0] g;
        logic mc;
    } vec_t;

    vec_t tv [25];

    initial begin
        #1_000_000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int a0, a1, stalls;
        bit seen, hit;
        tv = '{
            '{1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0},
            '{1'b0,1'b1,1'b0,1'b1,1'b1, 2'b00, 1'b0},
            '{1'b1,1'b0,1'b1,1'b0,1'b0, 2'b01, 1'b1},
            '{1'b1,1'b0,1'b1,1'b0,1'b0, 2'b01, 1'b1},
            '{1'b0,1'b0,1'b1,1'b0,1'b1, 2'b00, 1'b0},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 2'b10, 1'b1},
            '{1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0},
            '{1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0},
            '{1'b1,1'b0,1'b1,1'b0,1'b0, 2'b01, 1'b1},
            '{1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00, 1'b0},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0},
            '{1'b1,1'b0,1'b1,1'b0,1'b0, 2'b10, 1'b1},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0},
            '{1'b1,1'b0,1'b1,1'b0,1'b0, 2'b01, 1'b1},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0},
            '{1'b1,1'b0,1'b1,1'b0,1'b0, 2'b10, 1'b1},
            '{1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0},
            '{1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01, 1'b1},
            '{1'b1,1'b0,1'b1,1'b0,1'b0, 2'b01, 1'b1},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b0},
            '{1'b0,1'b0,1'b1,1'b0,1'b0, 2'b10, 1'b1},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0},
            '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0}
        };
        for (int i = 0; i < 16; i++) mmem[i] = 32'h1111_0000 + 32'(i);

        rst = 1'b1;
        mem_init = 1'b1;
        force_ack = 1'b0;
        no_ack = 1'b0;
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_init = 1'b0;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle after reset", {27'd0, grant, m_if.cyc, s0_if.ack, s1_if.ack},
                32'd0);
        end

        // arbitration table
        for (int i = 0; i < 25; i++) begin
            #1;
            drv(0, tv[i].c0, tv[i].s0, 1'b0, 32'h0, 32'h0);
            drv(1, tv[i].c1, tv[i].s1, 1'b0, 32'h0, 32'h0);
            force_ack = tv[i].fa;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vector %0d", i),
                {27'd0, grant, m_if.cyc, s0_if.ack, s1_if.ack},
                {27'd0, tv[i].g, tv[i].mc, 2'b00});
        end
        #1;
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        force_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // requester 0 writes, requester 1 reads back
        burst(0, 1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        burst(1, 1, 1'b0, 32'h10, 32'h0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // requester 1 read burst, requester 0 arrives mid-burst
        a0 = acks0;
        a1 = acks1;
        fork
            begin
                burst(1, 8, 1'b0, 32'h0, 32'h0, 1'b1);
                chk("burst acks to s1", 32'(acks1 - a1), 32'd8);
                chk("no s0 ack during burst", 32'(acks0 - a0), 32'd0);
                @(negedge clk);
                @(negedge clk);
                chk("gap after burst", {30'd0, grant}, 32'd0);
                @(negedge clk);
                chk("s0 granted after gap", {30'd0, grant}, 32'd1);
            end
            begin
                for (int k = 0; k < 200; k++) begin
                    @(posedge clk);
                    if (acks1 - a1 >= 2) break;
                end
                #1;
                burst(0, 1, 1'b1, 32'h20, 32'h5A5A_0001, 1'b0);
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // watchdog with a slave that never acks
        no_ack = 1'b1;
        drv(0, 1'b1, 1'b1, 1'b1, 32'h30, 32'h0000_1234);
        stalls = 0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (grant == 2'b01 && m_if.stb && !m_if.ack) stalls++;
            if (timeout_evt) begin seen = 1'b1; break; end
        end
        chk("timeout pulse seen", {31'd0, seen}, 32'd1);
        chk("stalled cycles at timeout", 32'(stalls), 32'd64);
        @(negedge clk);
        chk("timeout single pulse", {31'd0, timeout_evt}, 32'd0);
        chk("m cyc dropped after timeout", {31'd0, m_if.cyc}, 32'd0);
        chk("grant cleared after timeout", {30'd0, grant}, 32'd0);
        hit = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (grant[0] || m_if.cyc) hit = 1'b1;
        end
        chk("timed-out requester locked out", {31'd0, hit}, 32'd0);
        #1;
        drv(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("other requester granted", {30'd0, grant}, 32'd2);
        #1;
        drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        no_ack = 1'b0;
        drv(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lockout cleared", {30'd0, grant}, 32'd1);
        #1;
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        // reset in the middle of an OWN0 burst
        a0 = acks0;
        mmem[15] = 32'hC0FF_EE00;
        drv(0, 1'b1, 1'b1, 1'b1, 32'h3C, 32'hC0FF_EE00);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (acks0 - a0 >= 3) break;
        end
        #1;
        rst = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        chk("no ack during reset", {31'd0, s0_if.ack}, 32'd0);
        @(negedge clk);
        chk("m cyc after reset", {31'd0, m_if.cyc}, 32'd0);
        chk("grant after reset", {30'd0, grant}, 32'd0);
        chk("s0 ack after reset", {31'd0, s0_if.ack}, 32'd0);
        #1;
        force_ack = 1'b0;
        drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("acks before reset only", 32'(acks0 - a0), 32'd3);
        repeat (2) @(posedge clk);
        #1;
        burst(1, 1, 1'b0, 32'h3C, 32'h0, 1'b1);
        repeat (4) @(posedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, bytes per Wishbone data word, identical on all three ports.
REQ-002 SHALL have parameter TIMEOUT, default 64, watchdog cycles without ack before forced release (must be >= 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wb_s0  wshb_if.slave  DATA_BYTES  requester 0 (higher initial priority, e.g. display reader).
REQ-006 SHALL have port wb_s1  wshb_if.slave  DATA_BYTES  requester 1 (e.g. host writer).
REQ-007 SHALL have port wb_m  wshb_if.master  DATA_BYTES  shared link to the memory slave (wb_bram).
REQ-008 SHALL have port grant  output  2  one-hot registered owner status; bit0 = requester 0, bit1 = requester 1, 00 = idle.
REQ-009 SHALL have port timeout_evt  output  1  single-cycle pulse when the watchdog fires.

Function
REQ-010 SHALL implement FSM states IDLE, OWN0, OWN1, GAP, each registered.
REQ-011 In IDLE with only requester N asserting cyc, SHALL enter OWNN on the next edge; request-to-grant latency is exactly 1 cycle.
REQ-012 In IDLE with both cyc asserted, SHALL grant the requester not recorded in last_owner (round-robin); last_owner updates on each grant.
REQ-013 In OWNN, SHALL route cyc, stb, we, sel, adr and write data of requester N to wb_m unmodified and combinationally.
REQ-014 In OWNN, SHALL return wb_m ack and read data to requester N only; the other requester sees ack = 0 and read data = 0.
REQ-015 Ownership SHALL persist for the whole cycle; no preemption while the owner holds cyc, regardless of bursts.
REQ-016 When the owner deasserts cyc, SHALL enter GAP for exactly one cycle with wb_m cyc = stb = 0, then return to IDLE.
REQ-017 In IDLE and GAP, SHALL drive all wb_m request signals to 0 and both ack outputs to 0.
REQ-018 SHALL count consecutive owner cycles with stb = 1 and ack = 0; reset count on ack, on stb = 0 and on leaving OWNN.
REQ-019 When the count reaches TIMEOUT, SHALL pulse timeout_evt, force GAP on the next edge and drop wb_m cyc, even if the owner still asserts cyc.
REQ-020 After a timeout, SHALL ignore the timed-out requester until it deasserts cyc for at least one cycle.
REQ-021 A requester asserting stb without cyc SHALL be treated as not requesting.
REQ-022 An ack arriving from wb_m in IDLE or GAP SHALL be discarded and not forwarded.
REQ-023 The grant output SHALL be 01 in OWN0, 10 in OWN1, and 00 otherwise.

Reset
REQ-024 On rst = 1 at a clock edge, SHALL enter IDLE, set last_owner = 1 so requester 0 wins the first tie, clear the watchdog count and the lockout flags, and drive grant = 00 and timeout_evt = 0.
REQ-025 Reset asserted mid-transfer SHALL drop wb_m cyc/stb from the next edge; no ack SHALL be forwarded while rst = 1.

Structure
REQ-026 SHALL place the state enum (IDLE, OWN0, OWN1, GAP) and the grant encoding constants in shared package wb_arbiter_pkg.
REQ-027 SHALL be a single module with no sub-module; the routing mux stays inline.
REQ-028 The watchdog counter width SHALL be $clog2(TIMEOUT+1) bits.

Verification
REQ-029 Reset release with no cyc -> grant = 00, wb_m cyc = 0 and both acks 0 for 10 cycles.
REQ-030 Requester 0 writes 0xDEADBEEF to address 0x10, then requester 1 reads 0x10 -> read data = 0xDEADBEEF; each grant arrives 1 cycle after cyc; one GAP cycle between owners.
REQ-031 Both assert cyc on the same edge directly after reset -> requester 0 is granted first. On the next simultaneous request, requester 1 is granted (alternation over 4 rounds).
REQ-032 Requester 1 performs an 8-beat burst while requester 0 requests at beat 2 -> all 8 acks go to requester 1; requester 0 is granted 2 cycles after requester 1 drops cyc.
REQ-033 Slave stub never acks; TIMEOUT = 64 -> timeout_evt pulses once at the 64th stalled cycle; wb_m cyc drops the next cycle; the stuck requester is locked out until it drops cyc.
REQ-034 rst pulsed during an OWN0 burst at beat 3 -> wb_m cyc = 0 on the next edge; grant = 00; no further acks to requester 0.
